// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings,
// FSM state enum and iteration-counter sizing.
package muldiv_pkg;

    // op[OP_KIND] selects the operation, op[OP_SIGNED] requests signed arithmetic
    localparam int   OP_KIND   = 0;
    localparam int   OP_SIGNED = 1;
    localparam logic OP_MUL    = 1'b0;
    localparam logic OP_DIV    = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } muldiv_state_e;

    localparam int DEF_BITWIDTH = 32;

    function automatic int cnt_width(input int bw);
        return $clog2(bw);
    endfunction

    localparam int CNT_W = cnt_width(DEF_BITWIDTH);

endpackage

// File: rtl/muldiv_cond_neg.sv
// Combinational conditional two's-complement negate: o_val = i_neg ? -i_val : i_val.
module muldiv_cond_neg #(
    parameter int W = 32
) (
    input  logic         i_neg,
    input  logic [W-1:0] i_val,
    output logic [W-1:0] o_val
);

    logic [W-1:0] w_negated;

    assign w_negated = (~i_val) + {{(W-1){1'b0}}, 1'b1};
    assign o_val     = i_neg ? w_negated : i_val;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative shift-add multiplier / restoring divider with HI/LO result registers.
// Signed support is compiled in when MULDIV_SIGNED_EN is defined.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int bitwidth = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [1:0]          op,
    input  logic [bitwidth-1:0] a,
    input  logic [bitwidth-1:0] b,
    output logic                busy,
    output logic                done,
    output logic [bitwidth-1:0] hi,
    output logic [bitwidth-1:0] lo,
    output logic                div_by_zero,
    output logic [1:0]          o_dbg_state
);

    localparam int W  = bitwidth;
    localparam int CW = cnt_width(bitwidth);

    muldiv_state_e r_state;
    muldiv_state_e w_next_state;
    logic          w_load;
    logic          w_step;
    logic          w_finish;

    logic [CW-1:0]  r_cnt;
    logic           r_div;
    logic           r_b_zero;
    logic [W-1:0]   r_mcand;
    logic [W-1:0]   r_a_raw;
    logic [2*W-1:0] r_acc;
    logic           r_busy;
    logic           r_done;
    logic           r_dz;
    logic [W-1:0]   r_hi;
    logic [W-1:0]   r_lo;

    logic [W-1:0]   w_a_mag;
    logic [W-1:0]   w_b_mag;
    logic [2*W-1:0] w_prod_fix;
    logic [W-1:0]   w_quo_fix;
    logic [W-1:0]   w_rem_fix;

`ifdef MULDIV_SIGNED_EN
    logic w_signed;
    logic r_neg_lo;
    logic r_neg_hi;

    assign w_signed = op[OP_SIGNED];

    muldiv_cond_neg #(.W(W)) u_neg_a (
        .i_neg (w_signed & a[W-1]),
        .i_val (a),
        .o_val (w_a_mag)
    );

    muldiv_cond_neg #(.W(W)) u_neg_b (
        .i_neg (w_signed & b[W-1]),
        .i_val (b),
        .o_val (w_b_mag)
    );

    muldiv_cond_neg #(.W(2*W)) u_neg_prod (
        .i_neg (r_neg_lo),
        .i_val (r_acc),
        .o_val (w_prod_fix)
    );

    muldiv_cond_neg #(.W(W)) u_neg_quo (
        .i_neg (r_neg_lo),
        .i_val (r_acc[W-1:0]),
        .o_val (w_quo_fix)
    );

    // remainder follows the sign of the dividend
    muldiv_cond_neg #(.W(W)) u_neg_rem (
        .i_neg (r_neg_hi),
        .i_val (r_acc[2*W-1:W]),
        .o_val (w_rem_fix)
    );
`else
    logic w_unused_sign;

    assign w_unused_sign = op[OP_SIGNED];
    assign w_a_mag       = a;
    assign w_b_mag       = b;
    assign w_prod_fix    = r_acc;
    assign w_quo_fix     = r_acc[W-1:0];
    assign w_rem_fix     = r_acc[2*W-1:W];
`endif

    // r_acc holds {partial product, multiplier} or {partial remainder, dividend/quotient}
    logic [W:0]     w_mul_sum;
    logic [2*W-1:0] w_mul_next;
    logic [W:0]     w_div_shift;
    logic [W+1:0]   w_div_diff;
    logic [2*W-1:0] w_div_next;
    logic           w_unused_diff;

    assign w_mul_sum  = {1'b0, r_acc[2*W-1:W]} + {1'b0, r_mcand};
    assign w_mul_next = r_acc[0] ? {w_mul_sum, r_acc[W-1:1]}
                                 : {1'b0, r_acc[2*W-1:1]};

    assign w_div_shift   = {r_acc[2*W-1:W], r_acc[W-1]};
    assign w_div_diff    = {1'b0, w_div_shift} - {2'b00, r_mcand};
    assign w_unused_diff = w_div_diff[W];
    assign w_div_next    = w_div_diff[W+1] ? {w_div_shift[W-1:0], r_acc[W-2:0], 1'b0}
                                           : {w_div_diff[W-1:0],  r_acc[W-2:0], 1'b1};

    logic [W-1:0] w_res_hi;
    logic [W-1:0] w_res_lo;

    always_comb begin
        w_res_hi = w_prod_fix[2*W-1:W];
        w_res_lo = w_prod_fix[W-1:0];
        if (r_div) begin
            if (r_b_zero) begin
                w_res_hi = r_a_raw;
                w_res_lo = '1;
            end else begin
                w_res_hi = w_rem_fix;
                w_res_lo = w_quo_fix;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_step       = 1'b0;
        w_finish     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_load       = 1'b1;
                    w_next_state = S_CALC;
                end
            end
            S_CALC: begin
                w_step = 1'b1;
                if (r_cnt == '0) begin
                    w_next_state = S_FIX;
                end
            end
            S_FIX: begin
                w_finish     = 1'b1;
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt    <= '0;
            r_div    <= 1'b0;
            r_b_zero <= 1'b0;
            r_mcand  <= '0;
            r_a_raw  <= '0;
            r_acc    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_dz     <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
`ifdef MULDIV_SIGNED_EN
            r_neg_lo <= 1'b0;
            r_neg_hi <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            if (w_load) begin
                r_div    <= (op[OP_KIND] == OP_DIV);
                r_b_zero <= (b == '0);
                r_a_raw  <= a;
                r_cnt    <= CW'(W - 1);
                r_busy   <= 1'b1;
                // multiplier or dividend sits in the low half; the other operand is r_mcand
                if (op[OP_KIND] == OP_MUL) begin
                    r_acc   <= {{W{1'b0}}, w_b_mag};
                    r_mcand <= w_a_mag;
                end else begin
                    r_acc   <= {{W{1'b0}}, w_a_mag};
                    r_mcand <= w_b_mag;
                end
`ifdef MULDIV_SIGNED_EN
                r_neg_lo <= w_signed & (a[W-1] ^ b[W-1]);
                r_neg_hi <= w_signed & a[W-1];
`endif
            end
            if (w_step) begin
                r_acc <= r_div ? w_div_next : w_mul_next;
                r_cnt <= r_cnt - CW'(1);
            end
            if (w_finish) begin
                r_hi   <= w_res_hi;
                r_lo   <= w_res_lo;
                r_dz   <= r_div & r_b_zero;
                r_done <= 1'b1;
                r_busy <= 1'b0;
            end
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign hi          = r_hi;
    assign lo          = r_lo;
    assign div_by_zero = r_dz;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases plus randomized operations
// compared against an arithmetic reference model.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int BW = 32;

    logic          clk   = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [1:0]    op    = 2'b00;
    logic [BW-1:0] a     = '0;
    logic [BW-1:0] b     = '0;
    logic          busy;
    logic          done;
    logic          div_by_zero;
    logic [BW-1:0] hi;
    logic [BW-1:0] lo;
    logic [1:0]    dbg_state;

    int n_checks = 0;
    int n_errors = 0;
    logic [2*BW:0] last_exp;

    always #5 clk = ~clk;

    muldiv_unit #(.bitwidth(BW)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .hi          (hi),
        .lo          (lo),
        .div_by_zero (div_by_zero),
        .o_dbg_state (dbg_state)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
        n_checks++;
        assert (obs === want) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    // Reference model: returns {div_by_zero, hi, lo} from plain integer arithmetic.
    function automatic logic [2*BW:0] model(input logic [1:0] m_op, input logic [BW-1:0] m_a,
                                            input logic [BW-1:0] m_b);
        logic          sgn;
        longint        sa;
        longint        sb;
        logic [63:0]   p;
        logic [BW-1:0] q;
        logic [BW-1:0] r;
        sgn = 1'b0;
`ifdef MULDIV_SIGNED_EN
        sgn = m_op[1];
`endif
        sa = sgn ? longint'($signed(m_a)) : longint'(m_a);
        sb = sgn ? longint'($signed(m_b)) : longint'(m_b);
        if (!m_op[0]) begin
            p = 64'(sa * sb);
            return {1'b0, p};
        end
        if (m_b == '0) begin
            return {1'b1, m_a, {BW{1'b1}}};
        end
        if (sgn && m_a == 32'h8000_0000 && m_b == 32'hFFFF_FFFF) begin
            q = m_a;
            r = '0;
        end else begin
            q = BW'(sa / sb);
            r = BW'(sa % sb);
        end
        return {1'b0, r, q};
    endfunction

    // Called at a negedge; start is therefore sampled at the following posedge.
    task automatic run_op(input logic [1:0] t_op, input logic [BW-1:0] t_a,
                          input logic [BW-1:0] t_b, input string tag);
        logic [2*BW:0] want;
        bit            win_ok;
        want  = model(t_op, t_a, t_b);
        op    = t_op;
        a     = t_a;
        b     = t_b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        op    = 2'($urandom);
        a     = $urandom;
        b     = $urandom;
        win_ok = 1'b1;
        for (int n = 0; n <= BW; n++) begin
            if (busy !== 1'b1 || done !== 1'b0) win_ok = 1'b0;
            @(negedge clk);
        end
        check({tag, "_busy_window"}, 64'(win_ok), 64'd1);
        check({tag, "_done_busy"}, {62'd0, busy, done}, 64'b01);
        check({tag, "_hi"}, 64'(hi), 64'(want[2*BW-1:BW]));
        check({tag, "_lo"}, 64'(lo), 64'(want[BW-1:0]));
        check({tag, "_dz"}, 64'(div_by_zero), 64'(want[2*BW]));
        last_exp = want;
    endtask

    initial begin
        logic [1:0]    r_op;
        logic [BW-1:0] r_a;
        logic [BW-1:0] r_b;
        logic [2*BW:0] want;
        bit            win_ok;
        int            n_done;

        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_dz", 64'(div_by_zero), 64'd0);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        check("rst_state", 64'(dbg_state), 64'(S_IDLE));
        reset = 1'b0;
        @(negedge clk);

        run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "umul_max");
        check("umul_max_hi_const", 64'(hi), 64'hFFFF_FFFE);
        check("umul_max_lo_const", 64'(lo), 64'h0000_0001);

        run_op(2'b01, 32'd100, 32'd0, "udiv_zero");
        check("udiv_zero_lo_const", 64'(lo), 64'hFFFF_FFFF);
        check("udiv_zero_hi_const", 64'(hi), 64'h0000_0064);
        check("udiv_zero_dz_const", 64'(div_by_zero), 64'd1);

`ifdef MULDIV_SIGNED_EN
        run_op(2'b10, -32'sd3, 32'd5, "smul");
        check("smul_hi_const", 64'(hi), 64'hFFFF_FFFF);
        check("smul_lo_const", 64'(lo), 64'hFFFF_FFF1);
        run_op(2'b11, -32'sd7, 32'd2, "sdiv");
        check("sdiv_lo_const", 64'(lo), 64'hFFFF_FFFD);
        check("sdiv_hi_const", 64'(hi), 64'hFFFF_FFFF);
        check("sdiv_dz_const", 64'(div_by_zero), 64'd0);
        run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, "sdiv_ovf");
        check("sdiv_ovf_lo_const", 64'(lo), 64'h8000_0000);
        check("sdiv_ovf_hi_const", 64'(hi), 64'd0);
`else
        run_op(2'b11, -32'sd7, 32'd2, "sdiv_nosign");
        check("sdiv_nosign_lo_const", 64'(lo), 64'h7FFF_FFFC);
        check("sdiv_nosign_hi_const", 64'(hi), 64'h0000_0001);
`endif

        // done is a single-cycle pulse and results hold afterwards
        @(negedge clk);
        check("pulse_done_low", 64'(done), 64'd0);
        check("hold_hi", 64'(hi), 64'(last_exp[2*BW-1:BW]));
        check("hold_lo", 64'(lo), 64'(last_exp[BW-1:0]));
        check("hold_dz", 64'(div_by_zero), 64'(last_exp[2*BW]));

        // randomized back-to-back operations, starting in each done cycle
        for (int i = 0; i < 24; i++) begin
            r_op = 2'($urandom);
            r_a  = $urandom;
            r_b  = $urandom;
            case ($urandom_range(0, 5))
                0: r_b = '0;
                1: begin r_a = 32'h8000_0000; r_b = '1; end
                2: begin r_a = $urandom_range(0, 300); r_b = $urandom_range(1, 20); end
                3: r_b = $urandom_range(1, 3);
                default: ;
            endcase
            run_op(r_op, r_a, r_b, $sformatf("rand%0d", i));
        end
        @(negedge clk);

        // a start while busy is neither queued nor an abort
        want  = model(2'b00, 32'd12345, 32'd678);
        op    = 2'b00;
        a     = 32'd12345;
        b     = 32'd678;
        start = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        win_ok = 1'b1;
        for (int n = 0; n <= BW; n++) begin
            if (n == 5) begin
                op    = 2'b01;
                a     = 32'd999;
                b     = 32'd7;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (busy !== 1'b1 || done !== 1'b0) win_ok = 1'b0;
            @(negedge clk);
        end
        start = 1'b0;
        check("ign_busy_window", 64'(win_ok), 64'd1);
        check("ign_done", 64'(done), 64'd1);
        check("ign_hi", 64'(hi), 64'(want[2*BW-1:BW]));
        check("ign_lo", 64'(lo), 64'(want[BW-1:0]));
        n_done = 0;
        for (int n = 0; n < 2 * BW + 4; n++) begin
            @(negedge clk);
            if (done === 1'b1) n_done++;
        end
        check("ign_no_extra_done", 64'(n_done), 64'd0);

        // reset in the middle of an operation
        op    = 2'b01;
        a     = 32'd5000;
        b     = 32'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        #1;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_hi", 64'(hi), 64'd0);
        check("midrst_lo", 64'(lo), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        @(negedge clk);
        reset  = 1'b0;
        n_done = 0;
        for (int n = 0; n < 2 * BW + 4; n++) begin
            @(negedge clk);
            if (done === 1'b1) n_done++;
        end
        check("midrst_no_done", 64'(n_done), 64'd0);
        check("midrst_state", 64'(dbg_state), 64'(S_IDLE));

        run_op(2'b01, 32'd1000, 32'd7, "after_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multi-cycle multiply/divide unit for the datapath's execute stage. It accepts two `bitwidth`-bit operands on a start pulse and computes either a 2·`bitwidth` product or a quotient/remainder pair over `bitwidth`+1 cycles. Results are held in HI/LO registers. Those registers feed the write-back result selector directly, and the selector chooses between the ALU result and HI/LO.

## Interface
- `bitwidth`, default 32: operand and HI/LO width; must be ≥ 4.
- `clk` input 1: rising-edge clock.
- `reset` input 1: asynchronous, active-high reset.
- `start` input 1: request; sampled only in IDLE.
- `op` input 2:
  - `op[0]`: 0 = multiply, 1 = divide.
  - `op[1]`: 1 = signed operation.
- `a` input `bitwidth`: multiplicand / dividend; captured at start.
- `b` input `bitwidth`: multiplier / divisor; captured at start.
- `busy` output 1: high while an operation is in progress.
- `done` output 1: one-cycle pulse; HI/LO are valid in this cycle.
- `hi` output `bitwidth`:
  - multiply: upper half of the product.
  - divide: remainder.
- `lo` output `bitwidth`:
  - multiply: lower half of the product.
  - divide: quotient.
- `div_by_zero` output 1: valid with `done`; set for a divide with `b` = 0.

## Operation
- FSM states: IDLE, CALC, FIX.
- **IDLE**
  - On `start`, capture `a`, `b` and `op`.
  - Convert the operands to magnitudes if the operation is signed.
  - Load the iteration counter with `bitwidth`−1.
  - Go to CALC.
- **CALC**
  - One iteration per cycle:
    - multiply: shift-add, one multiplier bit per cycle.
    - divide: restoring, one quotient bit per cycle.
  - The counter decrements each cycle.
  - Leave for FIX when the counter = 0, after exactly `bitwidth` iterations.
- **FIX**
  - Apply the sign correction.
  - Load `hi`/`lo`.
  - Pulse `done` and return to IDLE.
- Signed multiply: the full 2·`bitwidth` two's-complement product.
- Signed divide:
  - The quotient truncates toward zero.
  - The remainder takes the sign of the dividend.
  - Most-negative ÷ −1 gives `lo` = most-negative and `hi` = 0. No trap.
- Divide by zero:
  - Runs the normal latency.
  - `lo` = all ones, `hi` = captured `a`, `div_by_zero` = 1 alongside `done`.
- `div_by_zero` holds its value until the next `done`.
- `start` while `busy` is ignored. It is neither queued nor an abort.
- `hi`/`lo` hold their values between operations and change only at a `done`.

## Timing
- Reset values: `busy` = 0, `done` = 0, `div_by_zero` = 0, `hi` = 0, `lo` = 0, state = IDLE.
- Reset mid-operation: return to IDLE immediately and clear all outputs. No `done` is produced.
- Timeline, where start is sampled at edge k:
  - `busy` is high in the cycles following edges k … k+`bitwidth`, i.e. `bitwidth`+1 cycles.
  - `hi`/`lo` update and `done` = 1 in the cycle following edge k+`bitwidth`+1.
  - Total latency: `bitwidth`+1 clocks from the start edge to results.
- `busy` is low during the `done` cycle. A `start` in that cycle is accepted, giving back-to-back operations every `bitwidth`+2 cycles.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- Macro: `MULDIV_SIGNED_EN`.
- Defined:
  - `op[1]` selects signed operation.
  - Operand magnitude conversion and FIX-state sign correction are compiled in.
- Undefined:
  - `op[1]` is ignored and every operation is unsigned.
  - Negation logic is removed. FIX only transfers the results.
  - Latency is unchanged.

## Structure
- Package `muldiv_pkg` holds:
  - op encodings (`OP_MUL`, `OP_DIV`, `OP_SIGNED` bit position).
  - the FSM state enum.
  - the counter width, `$clog2(bitwidth)`.
- Sub-module `muldiv_cond_neg`: combinational conditional two's-complement negate with a width parameter. It is instantiated:
  - for each operand's magnitude (width `bitwidth`).
  - for the result sign fix (width 2·`bitwidth` for the product, `bitwidth` for the quotient and remainder).

## Test plan
- Unsigned multiply: `a` = 0xFFFFFFFF, `b` = 0xFFFFFFFF → `done` 33 clocks after the start edge; `hi` = 0xFFFFFFFE, `lo` = 0x00000001.
- Signed multiply (macro defined): `a` = −3, `b` = 5 → `hi` = 0xFFFFFFFF, `lo` = 0xFFFFFFF1.
- Signed divide (macro defined): `a` = −7, `b` = 2 → `lo` = 0xFFFFFFFD, `hi` = 0xFFFFFFFF, `div_by_zero` = 0.
- Same −7 / 2 stimulus, macro undefined → unsigned result `lo` = 0x7FFFFFFC, `hi` = 0x00000001.
- Unsigned divide: `a` = 100, `b` = 0 → `lo` = 0xFFFFFFFF, `hi` = 0x00000064, `div_by_zero` = 1 alongside `done`.
- Second `start` pulsed 5 cycles into an operation → ignored, and only one `done` is seen. Then `reset` asserted mid-operation → `busy`/`hi`/`lo` = 0 immediately and no `done` follows.
